// File: rtl/amo_rmw_ctrl.sv
// AMO read-modify-write controller with an LR/SC reservation.
// One req/gnt/rvalid memory port; word ops use one 32-bit lane.
package ariane_pkg;
  typedef enum logic [3:0] {
    AMO_NONE = 4'd0,
    AMO_LR   = 4'd1,
    AMO_SC   = 4'd2,
    AMO_SWAP = 4'd3,
    AMO_ADD  = 4'd4,
    AMO_AND  = 4'd5,
    AMO_OR   = 4'd6,
    AMO_XOR  = 4'd7,
    AMO_MAX  = 4'd8,
    AMO_MAXU = 4'd9,
    AMO_MIN  = 4'd10,
    AMO_MINU = 4'd11,
    XAMO_INC = 4'd12,
    XAMO_DEC = 4'd13,
    AMO_CAS1 = 4'd14,
    AMO_CAS2 = 4'd15
  } amo_t;
endpackage

module amo_alu
  import ariane_pkg::*;
(
  input  amo_t        amo_op_i,
  input  logic [63:0] amo_a_i,
  input  logic [63:0] amo_b_i,
  output logic [63:0] amo_res_o
);
  logic lt_s, lt_u;

  assign lt_s = $signed(amo_a_i) < $signed(amo_b_i);
  assign lt_u = amo_a_i < amo_b_i;

  // SWAP and SC fall through to operand b
  always_comb begin
    amo_res_o = amo_b_i;
    case (amo_op_i)
      AMO_ADD:  amo_res_o = amo_a_i + amo_b_i;
      AMO_AND:  amo_res_o = amo_a_i & amo_b_i;
      AMO_OR:   amo_res_o = amo_a_i | amo_b_i;
      AMO_XOR:  amo_res_o = amo_a_i ^ amo_b_i;
      AMO_MAX:  amo_res_o = lt_s ? amo_b_i : amo_a_i;
      AMO_MAXU: amo_res_o = lt_u ? amo_b_i : amo_a_i;
      AMO_MIN:  amo_res_o = lt_s ? amo_a_i : amo_b_i;
      AMO_MINU: amo_res_o = lt_u ? amo_a_i : amo_b_i;
      XAMO_INC: amo_res_o = amo_a_i + 64'd1;
      XAMO_DEC: amo_res_o = amo_a_i - 64'd1;
      default:  amo_res_o = amo_b_i;
    endcase
  end
endmodule

module amo_rmw_ctrl
  import ariane_pkg::*;
#(
  parameter int unsigned ResvGranule = 6
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        amo_valid_i,
  output logic        amo_ready_o,
  input  amo_t        amo_op_i,
  input  logic [63:0] amo_addr_i,
  input  logic        amo_word_i,
  input  logic [63:0] amo_data_i,
  output logic        amo_resp_valid_o,
  output logic [63:0] amo_resp_data_o,
  output logic        amo_resp_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [7:0]  mem_be_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i
);
  localparam int unsigned RW = 64 - ResvGranule;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP
  } state_t;

  state_t      state_q, state_d;
  amo_t        op_q;
  logic        word_q, err_q;
  logic [63:2] addr_q;
  logic [63:0] data_q, rdata_q, resp_q;
  logic        resv_v_q;
  logic [RW-1:0] resv_a_q;

  logic        accept, misal, is_rmw, resv_hit, unsgn;
  logic [31:0] lane, rd_lane;
  logic [63:0] op_a, op_b, alu_res, rd_old;
  logic [7:0]  be;

  assign accept   = amo_valid_i && (state_q == IDLE);
  assign misal    = amo_word_i ? |amo_addr_i[1:0]
                               : |amo_addr_i[2:0];
  assign resv_hit = resv_v_q &&
    (resv_a_q == amo_addr_i[63:ResvGranule]);

  always_comb begin
    is_rmw = 1'b0;
    case (amo_op_i)
      AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR,
      AMO_XOR, AMO_MAX, AMO_MAXU, AMO_MIN,
      AMO_MINU, XAMO_INC, XAMO_DEC: is_rmw = 1'b1;
      default: is_rmw = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (amo_valid_i) begin
        if (misal)
          state_d = RESP;
        else if (amo_op_i == AMO_LR || is_rmw)
          state_d = RD_REQ;
        else if (amo_op_i == AMO_SC && resv_hit)
          state_d = WR_REQ;
        else
          state_d = RESP;
      end
      RD_REQ:  if (mem_gnt_i) state_d = RD_WAIT;
      RD_WAIT: if (mem_rvalid_i)
        state_d = (op_q == AMO_LR) ? RESP : WR_REQ;
      WR_REQ:  if (mem_gnt_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // MINU/MAXU compare word lanes as unsigned values
  assign unsgn = (op_q == AMO_MINU) || (op_q == AMO_MAXU);
  assign lane  = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
  assign op_a  = word_q ? {{32{lane[31] & ~unsgn}}, lane}
                        : rdata_q;
  assign op_b  = word_q
    ? {{32{data_q[31] & ~unsgn}}, data_q[31:0]} : data_q;

  amo_alu u_alu (
    .amo_op_i  (op_q),
    .amo_a_i   (op_a),
    .amo_b_i   (op_b),
    .amo_res_o (alu_res)
  );

  assign rd_lane = addr_q[2] ? mem_rdata_i[63:32]
                             : mem_rdata_i[31:0];
  assign rd_old  = word_q ? {{32{rd_lane[31]}}, rd_lane}
                          : mem_rdata_i;
  assign be = word_q ? (addr_q[2] ? 8'hF0 : 8'h0F) : 8'hFF;

  assign amo_ready_o      = rst_ni && (state_q == IDLE);
  assign mem_req_o        = (state_q == RD_REQ) ||
                            (state_q == WR_REQ);
  assign mem_we_o         = (state_q == WR_REQ);
  assign mem_addr_o       = mem_req_o ? {addr_q[63:3], 3'b000}
                                      : 64'd0;
  assign mem_be_o         = mem_req_o ? be : 8'h00;
  assign mem_wdata_o      = !mem_we_o ? 64'd0 :
    word_q ? {2{alu_res[31:0]}} : alu_res;
  assign amo_resp_valid_o = (state_q == RESP);
  assign amo_resp_data_o  = amo_resp_valid_o ? resp_q : 64'd0;
  assign amo_resp_err_o   = amo_resp_valid_o && err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q    <= AMO_NONE;
      word_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      if (accept) begin
        op_q   <= amo_op_i;
        word_q <= amo_word_i;
        addr_q <= amo_addr_i[63:2];
        data_q <= amo_data_i;
        err_q  <= misal;
        resp_q <= (!misal && amo_op_i == AMO_SC && !resv_hit)
                  ? 64'd1 : 64'd0;
      end
      if (state_q == RD_WAIT && mem_rvalid_i) begin
        rdata_q <= mem_rdata_i;
        resp_q  <= rd_old;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resv_v_q <= 1'b0;
      resv_a_q <= '0;
    end else if (accept && !misal && amo_op_i == AMO_SC) begin
      resv_v_q <= 1'b0;
    end else if (state_q == RD_WAIT && mem_rvalid_i &&
                 op_q == AMO_LR) begin
      resv_v_q <= 1'b1;
      resv_a_q <= addr_q[63:ResvGranule];
    end else if (state_q == WR_REQ && mem_gnt_i &&
                 resv_a_q == addr_q[63:ResvGranule]) begin
      resv_v_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_amo_rmw_ctrl.sv
// Randomized bench for amo_rmw_ctrl against a transaction-level
// model with its own memory image and reservation.
module tb_amo_rmw_ctrl;
  import ariane_pkg::*;
  localparam int RG = 6;

  logic        clk_i, rst_ni;
  logic        amo_valid_i, amo_ready_o, amo_word_i;
  amo_t        amo_op_i;
  logic [63:0] amo_addr_i, amo_data_i;
  logic        amo_resp_valid_o, amo_resp_err_o;
  logic [63:0] amo_resp_data_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [7:0]  mem_be_o;
  logic        mem_rvalid_i;

  amo_rmw_ctrl #(.ResvGranule(RG)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .amo_valid_i(amo_valid_i), .amo_ready_o(amo_ready_o),
    .amo_op_i(amo_op_i), .amo_addr_i(amo_addr_i),
    .amo_word_i(amo_word_i), .amo_data_i(amo_data_i),
    .amo_resp_valid_o(amo_resp_valid_o),
    .amo_resp_data_o(amo_resp_data_o),
    .amo_resp_err_o(amo_resp_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_vec = 0, n_err = 0;
  int n_rd = 0, n_wr = 0, n_hold = 0;
  int gnt_max = 0, rv_lo = 1, rv_hi = 1, stall_left = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [63:0] mem     [logic [60:0]];
  logic [63:0] ref_mem [logic [60:0]];
  bit          ref_rv = 0;
  logic [63:0] ref_rg = '0;

  function automatic logic [63:0] init_val(logic [60:0] k);
    return {k[31:0] ^ 32'h9E3779B9, ~k[31:0] + 32'h1234};
  endfunction
  function automatic logic [63:0] mem_get(logic [60:0] k);
    return mem.exists(k) ? mem[k] : init_val(k);
  endfunction
  function automatic logic [63:0] ref_get(logic [60:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : init_val(k);
  endfunction

  task automatic set_mem(input logic [63:0] a, input logic [63:0] v);
    mem[a[63:3]] = v;
    ref_mem[a[63:3]] = v;
  endtask

  // memory: random grant, rvalid 1+ cycles after a read grant
  int          rv_cnt = 0;
  logic [63:0] rv_data, last_wdata, p_addr, p_wdata;
  logic [7:0]  last_be, p_be;
  logic        p_we, g;
  bit          prev_hold = 0;

  always @(negedge clk_i) begin
    logic [63:0] w;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = {$urandom, $urandom};
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rv_data;
      end
    end
    if (prev_hold && rst_ni) begin
      n_hold++;
      chk("hold_ctl", {mem_req_o, mem_we_o, mem_be_o},
          {1'b1, p_we, p_be});
      chk("hold_addr", mem_addr_o, p_addr);
      chk("hold_wdata", mem_wdata_o, p_wdata);
    end
    g = 1'b0;
    if (mem_req_o) begin
      if (mem_we_o && stall_left > 0) stall_left--;
      else g = ($urandom_range(0, gnt_max) == 0);
    end
    mem_gnt_i = g;
    if (g && mem_we_o) begin
      w = mem_get(mem_addr_o[63:3]);
      for (int i = 0; i < 8; i++)
        if (mem_be_o[i]) w[8*i +: 8] = mem_wdata_o[8*i +: 8];
      mem[mem_addr_o[63:3]] = w;
      last_be = mem_be_o;
      last_wdata = mem_wdata_o;
      n_wr++;
    end else if (g) begin
      rv_data = mem_get(mem_addr_o[63:3]);
      rv_cnt  = $urandom_range(rv_lo, rv_hi);
      n_rd++;
    end
    prev_hold = mem_req_o && !g && rst_ni;
    p_we = mem_we_o; p_be = mem_be_o;
    p_addr = mem_addr_o; p_wdata = mem_wdata_o;
  end

  function automatic logic [31:0] alu32(amo_t op, logic [31:0] a,
                                         logic [31:0] b);
    case (op)
      AMO_ADD:  return a + b;
      AMO_AND:  return a & b;
      AMO_OR:   return a | b;
      AMO_XOR:  return a ^ b;
      AMO_MAX:  return ($signed(a) > $signed(b)) ? a : b;
      AMO_MIN:  return ($signed(a) < $signed(b)) ? a : b;
      AMO_MAXU: return (a > b) ? a : b;
      AMO_MINU: return (a < b) ? a : b;
      XAMO_INC: return a + 1;
      XAMO_DEC: return a - 1;
      default:  return b;
    endcase
  endfunction

  function automatic logic [63:0] alu64(amo_t op, logic [63:0] a,
                                         logic [63:0] b);
    case (op)
      AMO_ADD:  return a + b;
      AMO_AND:  return a & b;
      AMO_OR:   return a | b;
      AMO_XOR:  return a ^ b;
      AMO_MAX:  return ($signed(a) > $signed(b)) ? a : b;
      AMO_MIN:  return ($signed(a) < $signed(b)) ? a : b;
      AMO_MAXU: return (a > b) ? a : b;
      AMO_MINU: return (a < b) ? a : b;
      XAMO_INC: return a + 1;
      XAMO_DEC: return a - 1;
      default:  return b;
    endcase
  endfunction

  task automatic model(input amo_t op, input logic [63:0] addr,
                       input logic word, input logic [63:0] data,
                       output logic [63:0] rsp, output logic err,
                       output int rd, output int wr);
    logic [63:0] w, r64;
    logic [31:0] a32, r32;
    bit hit;
    w   = ref_get(addr[63:3]);
    a32 = addr[2] ? w[63:32] : w[31:0];
    hit = ref_rv && (ref_rg == (addr >> RG));
    rsp = '0; err = 0; rd = 0; wr = 0; r32 = '0; r64 = '0;
    if (word ? (addr[1:0] != 0) : (addr[2:0] != 0)) begin
      err = 1;
      return;
    end
    case (op)
      AMO_LR: begin
        rd = 1;
        rsp = word ? {{32{a32[31]}}, a32} : w;
        ref_rv = 1;
        ref_rg = addr >> RG;
      end
      AMO_SC: begin
        if (hit) begin
          wr = 1; r32 = data[31:0]; r64 = data;
        end else rsp = 1;
        ref_rv = 0;
      end
      AMO_NONE, AMO_CAS1, AMO_CAS2: ;
      default: begin
        rd = 1; wr = 1;
        rsp = word ? {{32{a32[31]}}, a32} : w;
        r32 = alu32(op, a32, data[31:0]);
        r64 = alu64(op, w, data);
      end
    endcase
    if (wr != 0) begin
      if (!word) w = r64;
      else if (addr[2]) w[63:32] = r32;
      else w[31:0] = r32;
      ref_mem[addr[63:3]] = w;
      if (hit) ref_rv = 0;
    end
  endtask

  task automatic run_amo(input amo_t op, input logic [63:0] addr,
                         input logic word, input logic [63:0] data,
                         input bit chk_lat);
    logic [63:0] e_rsp;
    logic e_err;
    int e_rd, e_wr, rd0, wr0, lat, n;
    bit got;
    model(op, addr, word, data, e_rsp, e_err, e_rd, e_wr);
    @(negedge clk_i);
    n = 0;
    while (!amo_ready_o && n < 50) begin
      @(negedge clk_i); n++;
    end
    chk("ready", amo_ready_o, 1);
    amo_valid_i = 1'b1; amo_op_i = op; amo_addr_i = addr;
    amo_word_i = word; amo_data_i = data;
    rd0 = n_rd; wr0 = n_wr;
    @(posedge clk_i); #1;
    amo_valid_i = 1'b0;
    amo_op_i = amo_t'(4'($urandom_range(0, 15)));
    amo_addr_i = {$urandom, $urandom};
    amo_word_i = 1'($urandom_range(0, 1));
    amo_data_i = {$urandom, $urandom};
    lat = 0; got = 0;
    while (!got && lat < 60) begin
      @(negedge clk_i); lat++;
      if (amo_resp_valid_o) got = 1;
    end
    chk("resp_seen", got, 1);
    if (got) begin
      chk("resp_data", amo_resp_data_o, e_rsp);
      chk("resp_err", amo_resp_err_o, e_err);
      if (chk_lat) chk("latency", lat, 4);
      @(negedge clk_i);
      chk("strobe_1cyc", amo_resp_valid_o, 0);
    end
    chk("reads", n_rd - rd0, e_rd);
    chk("writes", n_wr - wr0, e_wr);
    chk("mem_word", mem_get(addr[63:3]), ref_get(addr[63:3]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    amo_t op;
    logic [3:0] t4;
    logic [63:0] a;
    logic w;
    int rd0, wr0, h0, n;
    bit seen;

    rst_ni = 1'b0; amo_valid_i = 1'b0; amo_op_i = AMO_NONE;
    amo_addr_i = '0; amo_word_i = 1'b0; amo_data_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_ctl", {amo_ready_o, mem_req_o, mem_we_o,
        amo_resp_valid_o, amo_resp_err_o}, 0);
    chk("rst_outs", mem_addr_o | mem_wdata_o | amo_resp_data_o
        | 64'(mem_be_o), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", amo_ready_o, 1);

    // 64-bit add, immediate grant, minimum latency
    set_mem(64'h1000, 64'd5);
    run_amo(AMO_ADD, 64'h1000, 1'b0, 64'd3, 1);
    chk("add_be", last_be, 8'hFF);
    chk("add_wdata", last_wdata, 64'd8);

    set_mem(64'h1000, 64'hFFFFFFFF_12345678);
    run_amo(AMO_MINU, 64'h1004, 1'b1, 64'd1, 1);
    chk("minu_be", last_be, 8'hF0);
    chk("minu_wdata", last_wdata, 64'h00000001_00000001);

    run_amo(AMO_LR, 64'h2000, 1'b0, 64'd0, 0);
    run_amo(AMO_SC, 64'h2008, 1'b0, 64'd7, 0);
    chk("sc_wdata", last_wdata, 64'd7);
    run_amo(AMO_SC, 64'h2000, 1'b0, 64'd9, 0);

    run_amo(AMO_LR, 64'h3000, 1'b0, 64'd0, 0);
    run_amo(AMO_SWAP, 64'h3010, 1'b0, 64'd11, 0);
    run_amo(AMO_SC, 64'h3000, 1'b0, 64'd12, 0);

    run_amo(AMO_OR, 64'h1004, 1'b0, 64'hFF, 0);
    run_amo(AMO_NONE, 64'h1000, 1'b0, 64'hFF, 0);
    run_amo(AMO_LR, 64'h1002, 1'b1, 64'd0, 0);

    // write grant withheld three cycles
    stall_left = 3;
    h0 = n_hold;
    run_amo(AMO_XOR, 64'h1000, 1'b0, 64'hF0F0, 0);
    chk("stall_holds", n_hold - h0, 3);

    // reset while waiting for read data
    run_amo(AMO_LR, 64'h5000, 1'b0, 64'd0, 0);
    rv_lo = 6; rv_hi = 6;
    @(negedge clk_i);
    amo_valid_i = 1'b1; amo_op_i = AMO_ADD;
    amo_addr_i = 64'h6000; amo_word_i = 1'b0; amo_data_i = 64'd1;
    rd0 = n_rd; wr0 = n_wr;
    @(posedge clk_i); #1;
    amo_valid_i = 1'b0;
    n = 0;
    while (n_rd == rd0 && n < 20) begin
      @(negedge clk_i); n++;
    end
    chk("abort_rd_issued", n_rd - rd0, 1);
    rst_ni = 1'b0;
    ref_rv = 0;
    @(negedge clk_i);
    chk("abort_rst_ctl", {amo_ready_o, mem_req_o,
        amo_resp_valid_o}, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("abort_ready", amo_ready_o, 1);
    seen = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (amo_resp_valid_o || mem_req_o) seen = 1;
    end
    chk("abort_quiet", seen, 0);
    chk("abort_no_wr", n_wr - wr0, 0);
    chk("abort_mem", mem_get(61'h6000 >> 3),
        ref_get(61'h6000 >> 3));
    rv_lo = 1; rv_hi = 1;
    run_amo(AMO_SC, 64'h5000, 1'b0, 64'd9, 0);

    gnt_max = 2; rv_lo = 1; rv_hi = 3;
    for (int i = 0; i < 250; i++) begin
      t4 = 4'($urandom_range(0, 15));
      op = amo_t'(t4);
      if ($urandom_range(0, 3) == 0)
        op = ($urandom_range(0, 1) != 0) ? AMO_LR : AMO_SC;
      w = 1'($urandom_range(0, 1));
      a = 64'h8000 + 64'($urandom_range(0, 15)) * 8;
      if (w) a[2] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0 && op != AMO_NONE &&
          op != AMO_CAS1 && op != AMO_CAS2)
        a[1:0] = 2'($urandom_range(1, 3));
      run_amo(op, a, w, {$urandom, $urandom}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
